// File: rtl/bp_be_fe_queue_rollback_fifo.sv
// Rollback FIFO between the frontend and the backend checker. It keeps three pointers: write,
// speculative read and committed head, supporting speculative read-ahead, multi-entry commit, rollback and clear.
module bp_be_fe_queue_rollback_fifo #(
    parameter int width_p     = 64,
    parameter int els_p       = 8,
    parameter int deq_width_p = 2,
    localparam int ptr_width_lp     = $clog2(els_p) + 1,
    localparam int cnt_width_lp     = $clog2(els_p + 1),
    localparam int deq_cnt_width_lp = $clog2(deq_width_p + 1)
) (
    input  logic                        clk_i,
    input  logic                        reset_n_i,
    input  logic [width_p-1:0]          data_i,
    input  logic                        v_i,
    output logic                        ready_o,
    output logic [width_p-1:0]          data_o,
    output logic                        v_o,
    input  logic                        yumi_i,
    input  logic [deq_cnt_width_lp-1:0] deq_cnt_i,
    input  logic                        roll_i,
    input  logic                        clr_i,
    output logic [cnt_width_lp-1:0]     count_o,
    output logic [cnt_width_lp-1:0]     spec_count_o
);

    localparam int idx_width_lp = ptr_width_lp - 1;

    logic [ptr_width_lp-1:0] wptr_reg, wptr_next;
    logic [ptr_width_lp-1:0] rptr_reg, rptr_next;
    logic [ptr_width_lp-1:0] cptr_reg, cptr_next;
    logic [ptr_width_lp-1:0] count_ptr, spec_ptr;
    logic [idx_width_lp-1:0] widx, ridx;
    logic                    full;
    logic                    enq;

    logic [width_p-1:0] mem [els_p];

    assign widx = wptr_reg[idx_width_lp-1:0];
    assign ridx = rptr_reg[idx_width_lp-1:0];

    // Wrap bit makes the modulo difference distinguish full from empty.
    assign count_ptr    = wptr_reg - cptr_reg;
    assign spec_ptr     = rptr_reg - cptr_reg;
    assign count_o      = cnt_width_lp'(count_ptr);
    assign spec_count_o = cnt_width_lp'(spec_ptr);
    assign full         = (count_ptr == ptr_width_lp'(els_p));
    assign ready_o      = ~full;
    assign v_o          = (rptr_reg != wptr_reg);
    assign data_o       = mem[ridx];

    always_comb begin
        wptr_next = wptr_reg;
        rptr_next = rptr_reg;
        cptr_next = cptr_reg;
        enq       = 1'b0;
        if (clr_i) begin
            rptr_next = wptr_reg;
            cptr_next = wptr_reg;
        end else begin
            enq = v_i & ready_o;
            if (enq) begin
                wptr_next = wptr_reg + 1'b1;
            end
            cptr_next = cptr_reg + ptr_width_lp'(deq_cnt_i);
            // Rollback lands on the post-commit head so a same-cycle commit is honoured.
            if (roll_i) begin
                rptr_next = cptr_next;
            end else begin
                rptr_next = rptr_reg + ptr_width_lp'(yumi_i);
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wptr_reg <= '0;
            rptr_reg <= '0;
            cptr_reg <= '0;
        end else begin
            wptr_reg <= wptr_next;
            rptr_reg <= rptr_next;
            cptr_reg <= cptr_next;
        end
    end

    // Storage is left unreset; each slot loads only when the write index selects it.
    generate
        for (genvar gi = 0; gi < els_p; gi++) begin : g_slot
            always_ff @(posedge clk_i) begin
                if (enq && (widx == idx_width_lp'(gi))) begin
                    mem[gi] <= data_i;
                end
            end
        end
    endgenerate

`ifndef SYNTHESIS
    assert property (@(posedge clk_i) disable iff (!reset_n_i)
        (clr_i || !yumi_i || v_o))
        else $error("yumi_i asserted with no unread entry");

    assert property (@(posedge clk_i) disable iff (!reset_n_i)
        (clr_i || ((cnt_width_lp + 1)'(deq_cnt_i) <=
                   ({1'b0, spec_count_o} + (cnt_width_lp + 1)'(yumi_i)))))
        else $error("deq_cnt_i exceeds read-but-uncommitted entries");
`endif

endmodule

// File: tb/tb_bp_be_fe_queue_rollback_fifo.sv
// Directed bench for the rollback FIFO: vector table plus stream, clear and async-reset sequences.
`timescale 1ns/1ps
module tb_bp_be_fe_queue_rollback_fifo;

    logic        clk;
    logic        reset_n;
    logic [63:0] data_i;
    logic        v_i;
    logic        ready_o;
    logic [63:0] data_o;
    logic        v_o;
    logic        yumi_i;
    logic [1:0]  deq_cnt_i;
    logic        roll_i;
    logic        clr_i;
    logic [3:0]  count_o;
    logic [3:0]  spec_count_o;

    int checks = 0;
    int errors = 0;

    bp_be_fe_queue_rollback_fifo #(.width_p(64), .els_p(8), .deq_width_p(2)) dut (
        .clk_i       (clk),
        .reset_n_i   (reset_n),
        .data_i      (data_i),
        .v_i         (v_i),
        .ready_o     (ready_o),
        .data_o      (data_o),
        .v_o         (v_o),
        .yumi_i      (yumi_i),
        .deq_cnt_i   (deq_cnt_i),
        .roll_i      (roll_i),
        .clr_i       (clr_i),
        .count_o     (count_o),
        .spec_count_o(spec_count_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [63:0] d;
        logic        yumi;
        logic [1:0]  deq;
        logic        roll;
        logic        clr;
        logic [3:0]  cnt;
        logic [3:0]  spec;
        logic        vo;
        logic        rdy;
        logic [63:0] dout;
        logic        chk_d;
    } vec_t;

    vec_t vq[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic add(input logic v, input logic [63:0] d, input logic yumi, input logic [1:0] deq,
                       input logic roll, input logic clr, input logic [3:0] cnt, input logic [3:0] spec,
                       input logic vo, input logic rdy, input logic [63:0] dout, input logic chk_d);
        vec_t e;
        e.v = v; e.d = d; e.yumi = yumi; e.deq = deq; e.roll = roll; e.clr = clr;
        e.cnt = cnt; e.spec = spec; e.vo = vo; e.rdy = rdy; e.dout = dout; e.chk_d = chk_d;
        vq.push_back(e);
    endtask

    task automatic idle();
        v_i = 1'b0; data_i = '0; yumi_i = 1'b0; deq_cnt_i = '0; roll_i = 1'b0; clr_i = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int sent, rcvd, exp_rd, cyc;
        idle();
        reset_n = 1'b0;
        step();
        step();
        reset_n = 1'b1;
        $display("reset: count=%0d spec=%0d v=%0b ready=%0b", count_o, spec_count_o, v_o, ready_o);
        check("reset count", 64'(count_o), 64'd0);
        check("reset spec", 64'(spec_count_o), 64'd0);
        check("reset v_o", 64'(v_o), 64'd0);
        check("reset ready", 64'(ready_o), 64'd1);

        // Fill with A0..A7, head stays A0.
        for (int i = 0; i < 8; i++)
            add(1, 64'hA0 + 64'(i), 0, 0, 0, 0, 4'(i + 1), 0, 1, (i < 7), 64'hA0, 1);
        // Speculative reads while full; a blocked enqueue of FF rides along on the first.
        add(1, 64'hFF, 1, 0, 0, 0, 8, 1, 1, 0, 64'hA1, 1);
        add(0, 0, 1, 0, 0, 0, 8, 2, 1, 0, 64'hA2, 1);
        add(0, 0, 1, 0, 0, 0, 8, 3, 1, 0, 64'hA3, 1);
        add(0, 0, 0, 0, 1, 0, 8, 0, 1, 0, 64'hA0, 1);
        add(0, 0, 1, 0, 0, 0, 8, 1, 1, 0, 64'hA1, 1);
        add(0, 0, 1, 0, 0, 0, 8, 2, 1, 0, 64'hA2, 1);
        add(0, 0, 1, 0, 0, 0, 8, 3, 1, 0, 64'hA3, 1);
        // Commit two together with rollback: head moves to A2.
        add(0, 0, 0, 2, 1, 0, 6, 0, 1, 1, 64'hA2, 1);
        // Clear with enqueue and yumi in the same cycle.
        add(1, 64'hEE, 1, 0, 0, 1, 0, 0, 0, 1, 64'h0, 0);
        add(1, 64'hB0, 0, 0, 0, 0, 1, 0, 1, 1, 64'hB0, 1);
        add(0, 0, 1, 0, 0, 0, 1, 1, 0, 1, 64'h0, 0);

        for (int i = 0; i < vq.size(); i++) begin
            v_i = vq[i].v; data_i = vq[i].d; yumi_i = vq[i].yumi; deq_cnt_i = vq[i].deq;
            roll_i = vq[i].roll; clr_i = vq[i].clr;
            step();
            idle();
            $display("vec%0d: count=%0d spec=%0d v=%0b ready=%0b data=%0h", i, count_o, spec_count_o, v_o, ready_o, data_o);
            check($sformatf("vec%0d count", i), 64'(count_o), 64'(vq[i].cnt));
            check($sformatf("vec%0d spec", i), 64'(spec_count_o), 64'(vq[i].spec));
            check($sformatf("vec%0d v_o", i), 64'(v_o), 64'(vq[i].vo));
            check($sformatf("vec%0d ready", i), 64'(ready_o), 64'(vq[i].rdy));
            if (vq[i].chk_d) check($sformatf("vec%0d data", i), data_o, vq[i].dout);
        end

        // Streaming across three pointer wraps: enqueue, read and commit one per cycle.
        clr_i = 1'b1;
        step();
        idle();
        check("pre-stream count", 64'(count_o), 64'd0);
        sent = 0; rcvd = 0; exp_rd = 0; cyc = 0;
        while (!(rcvd == 24 && count_o == 0) && cyc < 300) begin
            idle();
            if (v_o) begin
                check($sformatf("stream data %0d", exp_rd), data_o, 64'h1000 + 64'(exp_rd));
                $display("stream: read %0h", data_o);
                exp_rd++;
                rcvd++;
                yumi_i = 1'b1;
            end
            if (spec_count_o >= 1) deq_cnt_i = 2'd1;
            if (sent < 24) begin
                v_i = 1'b1;
                data_i = 64'h1000 + 64'(sent);
                if (ready_o) sent++;
            end
            step();
            cyc++;
        end
        idle();
        check("stream received", 64'(rcvd), 64'd24);
        check("stream drained count", 64'(count_o), 64'd0);
        check("stream drained v_o", 64'(v_o), 64'd0);

        // Asynchronous reset mid-cycle with five entries queued.
        for (int i = 0; i < 5; i++) begin
            v_i = 1'b1; data_i = 64'hC0 + 64'(i);
            step();
        end
        idle();
        check("pre-reset count", 64'(count_o), 64'd5);
        #3;
        reset_n = 1'b0;
        #1;
        $display("async reset: count=%0d v=%0b ready=%0b", count_o, v_o, ready_o);
        check("async reset count", 64'(count_o), 64'd0);
        check("async reset spec", 64'(spec_count_o), 64'd0);
        check("async reset v_o", 64'(v_o), 64'd0);
        check("async reset ready", 64'(ready_o), 64'd1);
        step();
        step();
        #2;
        reset_n = 1'b1;
        step();
        v_i = 1'b1; data_i = 64'hD0;
        step();
        idle();
        $display("post-reset enqueue: count=%0d v=%0b data=%0h", count_o, v_o, data_o);
        check("post-reset count", 64'(count_o), 64'd1);
        check("post-reset v_o", 64'(v_o), 64'd1);
        check("post-reset data", data_o, 64'hD0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bp_be_fe_queue_rollback_fifo.md
Name: bp_be_fe_queue_rollback_fifo

Overview:
- Parametrised rollback FIFO that buffers fetch packets between the frontend and the backend checker.
- Keeps separate write, speculative-read and committed-head pointers, so the backend can read ahead speculatively and then do one of three things:
  - commit several entries per cycle,
  - roll back to the committed head,
  - clear the whole queue.
- Generalises the single-entry clr/deq/roll queue interface to configurable depth, packet width and multi-entry commit.

Parameters:
- width_p, 64, bits per queued packet
- els_p, 8, queue depth; must be a power of two and at least 2
- deq_width_p, 2, maximum entries committed in one cycle; 1 <= deq_width_p <= els_p
- ptr_width_lp, $clog2(els_p)+1, pointer width: index plus wrap bit (localparam)
- cnt_width_lp, $clog2(els_p+1), occupancy width (localparam)
- deq_cnt_width_lp, $clog2(deq_width_p+1), commit-count width (localparam)

Ports:
- clk_i  in  1  clock; all state updates on rising edge
- reset_n_i  in  1  asynchronous, active-low reset
- data_i  in  width_p  enqueue packet
- v_i  in  1  enqueue valid
- ready_o  out  1  space available; enqueue occurs when v_i & ready_o
- data_o  out  width_p  packet at speculative-read pointer
- v_o  out  1  data_o valid: an unread entry exists
- yumi_i  in  1  consumer takes data_o this cycle; legal only when v_o=1
- deq_cnt_i  in  deq_cnt_width_lp  number of oldest read entries to commit; 0 means no commit
- roll_i  in  1  restore speculative-read pointer to committed head
- clr_i  in  1  discard all entries
- count_o  out  cnt_width_lp  entries held, from committed head to write pointer
- spec_count_o  out  cnt_width_lp  entries read but not committed

Behaviour:
- State:
  - wptr, rptr and cptr, each ptr_width_lp bits.
  - Storage is els_p x width_p flops.
  - The index is the low bits of a pointer; the MSB is the wrap bit.
- Reset (reset_n_i=0, asynchronous): all pointers go to 0. Outputs: v_o=0, ready_o=1, count_o=0, spec_count_o=0. Storage is not reset; data_o is don't-care while v_o=0.
- Derived signals (combinational from registered pointers):
  - count_o = wptr - cptr, modulo 2^ptr_width_lp
  - spec_count_o = rptr - cptr
  - full when count_o == els_p; ready_o = ~full
  - v_o = (rptr != wptr); data_o = mem[rptr index]
- Latency: an enqueued entry is visible on data_o the next cycle. There is no bypass from data_i to data_o.
- Per-cycle update, in priority order:
  1. clr_i=1: wptr, rptr and cptr all take the current wptr value. An enqueue in the same cycle is dropped, and yumi_i, deq_cnt_i and roll_i are ignored. Next cycle: count_o=0, v_o=0.
  2. Otherwise, enqueue: if v_i & ready_o, write mem[wptr index] and increment wptr.
  3. Commit: cptr_n = cptr + deq_cnt_i. The caller guarantees deq_cnt_i <= spec_count_o, counting a yumi in the same cycle.
  4. roll_i=1: rptr_n = cptr_n (the post-commit head) and yumi_i is ignored. Otherwise rptr_n = rptr + yumi_i.
- Freed slots: ready_o reflects the registered cptr. Slots freed by a commit become usable the next cycle, so there is no same-cycle enqueue into a slot being committed.
- Full and empty:
  - Enqueue when full is blocked by ready_o=0, and v_i is held by the producer.
  - yumi_i while v_o=0 is a protocol error (simulation assertion).
  - deq_cnt_i > spec_count_o + yumi_i is a protocol error (assertion).
- Wrap-around: pointers wrap modulo 2^ptr_width_lp. The wrap bit distinguishes full from empty when the indices are equal.
- Reset mid-operation: immediate clear to the reset state regardless of the clock. Queued data is lost.

Test Plan:
- Reset, then enqueue 8 packets 0xA0..0xA7 back-to-back → count_o=8, ready_o=0 after the 8th, v_o=1 from cycle 2, data_o=0xA0.
- From full: yumi 3 times → spec_count_o=3, data_o=0xA3. Then roll_i → spec_count_o=0, data_o=0xA0 again, count_o=8.
- From full: yumi 3, then deq_cnt_i=2 together with roll_i → count_o=6, spec_count_o=0, data_o=0xA2, ready_o=1 the next cycle.
- clr_i asserted with v_i=1 and yumi_i=1 in the same cycle → next cycle count_o=0, v_o=0, ready_o=1, and the dropped packet never appears.
- Continuous enqueue, yumi and deq_cnt_i=1 for 3*els_p packets with an incrementing pattern → in-order data, no loss or duplication across the pointer wrap, wrap bit toggles 3 times.
- Drop reset_n_i mid-clock with count_o=5 → outputs return to their reset values without a clock edge, and the queue accepts new data after reset is released.
